// File: rtl/sd_pkt_pkg.sv
// Shared types and constants for the sd_pkt_loader packet writer.
package sd_pkt_pkg;

    typedef enum logic [1:0] {
        S_DATA  = 2'd0,
        S_FLUSH = 2'd1,
        S_END   = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    localparam int STATS_W = 16;

endpackage

// File: rtl/sd_pkt_hold.sv
// One-entry srdy/drdy holding register; output side is fully registered.
module sd_pkt_hold #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_srdy_i,
    output logic         in_drdy_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_srdy_o,
    input  logic         out_drdy_i,
    output logic [W-1:0] out_data_o
);

    logic         v_q;
    logic [W-1:0] data_q;

    assign in_drdy_o  = ~v_q | out_drdy_i;
    assign out_srdy_o = v_q;
    assign out_data_o = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else if (in_srdy_i && in_drdy_o) begin
            v_q    <= 1'b1;
            data_q <= in_data_i;
        end else if (out_drdy_i) begin
            v_q    <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_pkt_loader.sv
// Packet loader writing a srdy/drdy packet stream into a commit/abort FIFO.
// Build option SD_PKT_LOADER_STATS_EN adds pkt_cnt/abort_cnt pulse counters.
//   state   | meaning
//   S_DATA  | accept words into the hold register
//   S_FLUSH | oversize word seen; drain hold, then end the packet
//   S_END   | one cycle: pulse c_commit or c_abort
//   S_DROP  | discard the rest of an oversize packet up to its eop
module sd_pkt_loader
    import sd_pkt_pkg::*;
#(
    parameter int width   = 8,
    parameter int max_len = 16,
    parameter int cnt_sz  = $clog2(max_len + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_srdy,
    output logic             i_drdy,
    input  logic [width-1:0] i_data,
    input  logic             i_eop,
    input  logic             i_err,
    output logic             c_srdy,
    input  logic             c_drdy,
    output logic [width-1:0] c_data,
    output logic             c_commit,
    output logic             c_abort
`ifdef SD_PKT_LOADER_STATS_EN
    ,
    output logic [STATS_W-1:0] pkt_cnt,
    output logic [STATS_W-1:0] abort_cnt
`endif
);

    localparam logic [cnt_sz-1:0] MAX_CNT = cnt_sz'(max_len);
    localparam logic [cnt_sz-1:0] CNT_ONE = cnt_sz'(1);

    state_t            state_q, state_d;
    logic [cnt_sz-1:0] count_q, count_d;
    logic              bad_q, bad_d;
    logic              drop_q, drop_d;
    logic              run_q;
    logic              hold_load;
    logic              hold_rdy;
    logic [width:0]    hold_word;
    logic              hold_eop;

    sd_pkt_hold #(.W(width + 1)) u_hold (
        .clk        (clk),
        .rst_n      (reset),
        .in_srdy_i  (hold_load),
        .in_drdy_o  (hold_rdy),
        .in_data_i  ({i_eop, i_data}),
        .out_srdy_o (c_srdy),
        .out_drdy_i (c_drdy),
        .out_data_o (hold_word)
    );

    assign hold_eop = hold_word[width];
    assign c_data   = hold_word[width-1:0];

    // Pulses decode straight from registered state so they never glitch.
    assign c_commit = (state_q == S_END) & ~bad_q;
    assign c_abort  = (state_q == S_END) &  bad_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_DATA;
            count_q <= '0;
            bad_q   <= 1'b0;
            drop_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bad_q   <= bad_d;
            drop_q  <= drop_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bad_d     = bad_q;
        drop_d    = drop_q;
        i_drdy    = 1'b0;
        hold_load = 1'b0;
        unique case (state_q)
            S_DATA: begin
                // A pending eop word blocks the next packet until its pulse is out.
                i_drdy = run_q & hold_rdy & ~(c_srdy & hold_eop);
                if (i_srdy && i_drdy) begin
                    bad_d = bad_q | i_err;
                    if (count_q == MAX_CNT) begin
                        bad_d   = 1'b1;
                        drop_d  = ~i_eop;
                        state_d = S_FLUSH;
                    end else begin
                        hold_load = 1'b1;
                        count_d   = count_q + CNT_ONE;
                    end
                end else if (c_srdy && c_drdy && hold_eop) begin
                    state_d = S_END;
                end
            end
            S_FLUSH: begin
                if (!c_srdy) state_d = S_END;
            end
            S_END: begin
                count_d = '0;
                bad_d   = 1'b0;
                state_d = drop_q ? S_DROP : S_DATA;
            end
            S_DROP: begin
                i_drdy = run_q;
                if (i_srdy && i_drdy && i_eop) begin
                    drop_d  = 1'b0;
                    state_d = S_DATA;
                end
            end
            default: state_d = S_DATA;
        endcase
    end

`ifdef SD_PKT_LOADER_STATS_EN
    logic [STATS_W-1:0] pkt_cnt_q;
    logic [STATS_W-1:0] abort_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q   <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (c_commit) pkt_cnt_q   <= pkt_cnt_q + STATS_W'(1);
            if (c_abort)  abort_cnt_q <= abort_cnt_q + STATS_W'(1);
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_sd_pkt_loader.sv
// Self-checking bench for sd_pkt_loader against a packet-level reference model.
// Stats ports are checked when SD_PKT_LOADER_STATS_EN is defined.
module tb_sd_pkt_loader;

    localparam int MAXL = 16;

    logic       clk;
    logic       reset;
    logic       i_srdy;
    logic       i_drdy;
    logic [7:0] i_data;
    logic       i_eop;
    logic       i_err;
    logic       c_srdy;
    logic       c_drdy;
    logic [7:0] c_data;
    logic       c_commit;
    logic       c_abort;
`ifdef SD_PKT_LOADER_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] abort_cnt;
`endif

    sd_pkt_loader #(.width(8), .max_len(MAXL)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_srdy   (i_srdy),
        .i_drdy   (i_drdy),
        .i_data   (i_data),
        .i_eop    (i_eop),
        .i_err    (i_err),
        .c_srdy   (c_srdy),
        .c_drdy   (c_drdy),
        .c_data   (c_data),
        .c_commit (c_commit),
        .c_abort  (c_abort)
`ifdef SD_PKT_LOADER_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .abort_cnt(abort_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] srdy_pat = 8'h5A;
    logic [7:0] drdy_pat = 8'hA5;
    int         pat_idx  = 0;
    int         bp_idx   = 0;
    bit         bp_en    = 0;

    logic [7:0] pkt_data [0:63];

    // reference model output: expected FIFO writes and pulses (1=commit, 2=abort)
    logic [7:0] exp_d[$];
    int         exp_p[$];

    // observed DUT behaviour
    logic [7:0] got_d[$];
    int         got_wc[$];
    int         got_p[$];
    int         got_pc[$];
    int         cyc        = 0;
    int         viol       = 0;
    int         stab_err   = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data  = '0;

    always @(negedge clk) begin
        if (reset) begin
            cyc++;
            if (c_srdy && c_drdy) begin
                got_d.push_back(c_data);
                got_wc.push_back(cyc);
            end
            if (c_commit) begin
                got_p.push_back(1);
                got_pc.push_back(cyc);
            end
            if (c_abort) begin
                got_p.push_back(2);
                got_pc.push_back(cyc);
            end
            if ((c_commit || c_abort) && (c_srdy || (c_commit && c_abort))) viol++;
            if (prev_stall && (!c_srdy || c_data !== prev_data)) stab_err++;
            prev_stall = c_srdy && !c_drdy;
            prev_data  = c_data;
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d required completion", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        c_drdy = bp_en ? drdy_pat[bp_idx % 8] : 1'b1;
        bp_idx++;
    endtask

    task automatic clear_q();
        exp_d.delete();
        exp_p.delete();
        got_d.delete();
        got_wc.delete();
        got_p.delete();
        got_pc.delete();
        viol     = 0;
        stab_err = 0;
    endtask

    // Packet-level rule: first max_len words reach the FIFO; any error or
    // overlength forces an abort, otherwise a commit.
    task automatic model_pkt(input int len, input int err_pos);
        for (int k = 0; k < len && k < MAXL; k++) exp_d.push_back(pkt_data[k]);
        exp_p.push_back((len > MAXL || err_pos >= 0) ? 2 : 1);
    endtask

    task automatic send_pkt(input int len, input int n_send, input int err_pos,
                            input bit use_pat, output bit timed_out);
        timed_out = 0;
        for (int k = 0; k < n_send; k++) begin
            bit done;
            int guard;
            done  = 0;
            guard = 0;
            i_data = pkt_data[k];
            i_eop  = (k == len - 1);
            i_err  = (k == err_pos);
            while (!done && !timed_out) begin
                i_srdy = use_pat ? srdy_pat[pat_idx % 8] : 1'b1;
                pat_idx++;
                @(negedge clk);
                done = i_srdy && i_drdy;
                tick();
                guard++;
                if (guard > 300) timed_out = 1;
            end
            if (timed_out) break;
        end
        i_srdy = 1'b0;
        i_eop  = 1'b0;
        i_err  = 1'b0;
    endtask

    task automatic wait_pulses(input int n);
        int guard;
        guard = 0;
        while (got_p.size() < n && guard < 600) begin
            tick();
            guard++;
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        i_srdy = 1'b0;
        i_data = '0;
        i_eop  = 1'b0;
        i_err  = 1'b0;
        c_drdy = 1'b1;
        repeat (3) tick();
        n_cmp++; if (c_srdy !== 1'b0)   begin n_bad++; $display("FAIL reset_c_srdy got %b need 0", c_srdy); end
        n_cmp++; if (c_commit !== 1'b0) begin n_bad++; $display("FAIL reset_c_commit got %b need 0", c_commit); end
        n_cmp++; if (c_abort !== 1'b0)  begin n_bad++; $display("FAIL reset_c_abort got %b need 0", c_abort); end
        n_cmp++; if (c_data !== 8'h00)  begin n_bad++; $display("FAIL reset_c_data got %h need 00", c_data); end
        n_cmp++; if (i_drdy !== 1'b0)   begin n_bad++; $display("FAIL reset_i_drdy got %b need 0", i_drdy); end
        reset = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_normal();
        bit to;
        clear_q();
        bp_en = 0;
        for (int k = 0; k < 4; k++) pkt_data[k] = 8'(k + 1);
        model_pkt(4, -1);
        send_pkt(4, 4, -1, 0, to);
        wait_pulses(1);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL normal_timeout got %b need 0", to); end
        n_cmp++;
        if (got_d.size() != 4) begin
            n_bad++; $display("FAIL normal_nwords got %0d need 4", got_d.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got_d[k] !== exp_d[k]) begin
                    n_bad++; $display("FAIL normal_word%0d got %h need %h", k, got_d[k], exp_d[k]);
                end
            end
            n_cmp++;
            if (got_wc[3] - got_wc[0] != 3) begin
                n_bad++; $display("FAIL normal_b2b span got %0d need 3", got_wc[3] - got_wc[0]);
            end
        end
        n_cmp++;
        if (got_p.size() != 1 || got_p[0] != 1) begin
            n_bad++; $display("FAIL normal_pulse got n=%0d need one commit", got_p.size());
        end else if (got_d.size() == 4) begin
            n_cmp++;
            if (got_pc[0] != got_wc[3] + 1) begin
                n_bad++; $display("FAIL normal_commit_cycle got %0d need %0d", got_pc[0], got_wc[3] + 1);
            end
        end
        n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL normal_pulse_rules got %0d need 0", viol); end
    endtask

    // Generic packet-list scenario: lens/errs describe consecutive packets.
    task automatic test_pkt_list(input string name, input int lens[$], input int errs[$], input bit pat);
        bit to;
        bit any_to;
        clear_q();
        bp_en  = pat;
        any_to = 0;
        for (int p = 0; p < lens.size(); p++) begin
            for (int k = 0; k < lens[p]; k++) pkt_data[k] = 8'($urandom);
            model_pkt(lens[p], errs[p]);
            send_pkt(lens[p], lens[p], errs[p], pat, to);
            any_to |= to;
        end
        wait_pulses(lens.size());
        bp_en = 0;
        n_cmp++; if (any_to !== 1'b0) begin n_bad++; $display("FAIL %s_timeout got %b need 0", name, any_to); end
        n_cmp++;
        if (got_d.size() != exp_d.size()) begin
            n_bad++; $display("FAIL %s_nwords got %0d need %0d", name, got_d.size(), exp_d.size());
        end else begin
            for (int k = 0; k < exp_d.size(); k++) begin
                n_cmp++;
                if (got_d[k] !== exp_d[k]) begin
                    n_bad++; $display("FAIL %s_word%0d got %h need %h", name, k, got_d[k], exp_d[k]);
                end
            end
        end
        n_cmp++;
        if (got_p.size() != exp_p.size()) begin
            n_bad++; $display("FAIL %s_npulses got %0d need %0d", name, got_p.size(), exp_p.size());
        end else begin
            for (int k = 0; k < exp_p.size(); k++) begin
                n_cmp++;
                if (got_p[k] != exp_p[k]) begin
                    n_bad++; $display("FAIL %s_pulse%0d got %0d need %0d (1=commit 2=abort)", name, k, got_p[k], exp_p[k]);
                end
            end
        end
        n_cmp++; if (viol != 0)     begin n_bad++; $display("FAIL %s_pulse_rules got %0d need 0", name, viol); end
        n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL %s_stall_stable got %0d need 0", name, stab_err); end
    endtask

    task automatic test_error();
        test_pkt_list("error", '{3, 2}, '{1, -1}, 0);
    endtask

    task automatic test_oversize();
        test_pkt_list("oversize", '{20, 1}, '{-1, -1}, 0);
    endtask

    task automatic test_exact_limit();
        test_pkt_list("exact", '{17, 16, 16}, '{-1, -1, 15}, 0);
    endtask

    task automatic test_backpressure();
        int lens[$];
        int errs[$];
        for (int p = 0; p < 50; p++) begin
            int len;
            len = $urandom_range(1, MAXL);
            lens.push_back(len);
            errs.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1);
        end
        test_pkt_list("backpressure", lens, errs, 1);
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_q();
        bp_en = 0;
        for (int k = 0; k < 5; k++) pkt_data[k] = 8'($urandom);
        send_pkt(5, 2, -1, 0, to);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (c_srdy !== 1'b0)   begin n_bad++; $display("FAIL rstmid_c_srdy got %b need 0", c_srdy); end
        n_cmp++; if (c_commit !== 1'b0) begin n_bad++; $display("FAIL rstmid_c_commit got %b need 0", c_commit); end
        n_cmp++; if (c_abort !== 1'b0)  begin n_bad++; $display("FAIL rstmid_c_abort got %b need 0", c_abort); end
        n_cmp++; if (c_data !== 8'h00)  begin n_bad++; $display("FAIL rstmid_c_data got %h need 00", c_data); end
        n_cmp++; if (i_drdy !== 1'b0)   begin n_bad++; $display("FAIL rstmid_i_drdy got %b need 0", i_drdy); end
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        clear_q();
        for (int k = 0; k < 3; k++) pkt_data[k] = 8'($urandom);
        model_pkt(3, -1);
        send_pkt(3, 3, -1, 0, to);
        wait_pulses(1);
        n_cmp++;
        if (got_d.size() != 3) begin
            n_bad++; $display("FAIL rstmid_nwords got %0d need 3", got_d.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (got_d[k] !== exp_d[k]) begin
                    n_bad++; $display("FAIL rstmid_word%0d got %h need %h", k, got_d[k], exp_d[k]);
                end
            end
        end
        n_cmp++;
        if (got_p.size() != 1 || got_p[0] != 1) begin
            n_bad++; $display("FAIL rstmid_pulse got n=%0d need one commit", got_p.size());
        end
`ifdef SD_PKT_LOADER_STATS_EN
        n_cmp++; if (pkt_cnt !== 16'd1)   begin n_bad++; $display("FAIL rstmid_pkt_cnt got %0d need 1", pkt_cnt); end
        n_cmp++; if (abort_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_abort_cnt got %0d need 0", abort_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_normal();
        test_error();
        test_oversize();
        test_exact_limit();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_pkt_loader.md
Name: sd_pkt_loader

Overview:
Producer-side packet loader for the commit/abort FIFO (sd_fifo_b). It accepts a packetized srdy/drdy stream (data, end-of-packet, error) and writes words into the FIFO's c_ interface through a one-entry output register. At each packet end it pulses c_commit to publish a good packet, or c_abort to rewind the FIFO write pointer for an errored or oversized packet. It is the write-end counterpart to the FIFO's commit/abort read path.

Parameters:
width, 8, data word width
max_len, 16, maximum legal packet length in words (1..depth of downstream FIFO)
cnt_sz, $clog2(max_len+1), packet word counter width (derived)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
i_srdy  in  1  input word valid
i_drdy  out  1  input word accepted when i_srdy&i_drdy
i_data  in  width  input data
i_eop  in  1  last word of packet
i_err  in  1  word is errored; packet must be aborted
c_srdy  out  1  FIFO write valid
c_drdy  in  1  FIFO write ready
c_data  out  width  FIFO write data
c_commit  out  1  one-cycle pulse: commit all words written since the last commit or abort
c_abort  out  1  one-cycle pulse: discard all words written since the last commit or abort

Behaviour:
- Reset (asynchronous, reset=0): state=S_DATA, hold_v=0, count=0, bad=0, drop=0. c_srdy=0, c_commit=0, c_abort=0, c_data=0, i_drdy=0.
- Hold register: hold_v, hold_data, hold_eop. c_srdy=hold_v, c_data=hold_data. Input-to-FIFO latency is 1 cycle. Back-to-back throughput is 1 word/cycle.
- S_DATA: i_drdy = ~hold_v | c_drdy (combinational). On accept, count increments and bad |= i_err.
  - Normal word (count<max_len before accept): the word loads into hold with hold_eop=i_eop.
  - Oversize word (count==max_len before accept, i.e. word max_len+1): the word is not loaded and bad is set. If i_eop=1, drop=0; otherwise drop=1. Go to S_FLUSH.
  - When hold is drained (c_srdy&c_drdy) with hold_eop=1 and no new load, go to S_END. i_drdy is held 0 while a hold_eop word is pending.
- S_FLUSH: i_drdy=0. Wait until hold_v=0 (hold drains normally), then go to S_END.
- S_END: exactly one cycle. c_commit=~bad and c_abort=bad, mutually exclusive. i_drdy=0, c_srdy=0. Clear count and bad. Next state is S_DROP if drop=1, else S_DATA.
- S_DROP: i_drdy=1. Discard words until a word with i_eop is accepted (that word is discarded too), then clear drop and go to S_DATA. No FIFO writes or pulses occur in this state.
- i_err on any word, including the eop word, forces c_abort for that packet. Errored words are still written to the FIFO.
- A single-word packet (i_eop on the first word) is legal: write, then a commit pulse.
- c_commit/c_abort are registered outputs, never asserted in the same cycle as c_srdy.
- Reset mid-packet clears all state. The FIFO's own reset discards uncommitted data.
- c_drdy held low indefinitely stalls the block with hold kept stable. There is no timeout.

Optional Feature:
SD_PKT_LOADER_STATS_EN
- Defined: adds output ports pkt_cnt[15:0] and abort_cnt[15:0]. pkt_cnt increments on every c_commit pulse; abort_cnt increments on every c_abort pulse. Both wrap at 16'hFFFF->0 and reset to 0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package sd_pkt_pkg: state enum (S_DATA, S_FLUSH, S_END, S_DROP) and the stats counter width constant (16).
- Sub-module sd_pkt_hold: one-entry srdy/drdy holding register carrying {eop, data}. The loader FSM wraps it.

Test Plan:
- Normal packet: max_len=16, 4 words 01..04 with eop on 04, c_drdy=1 -> FIFO sees 01..04 on 4 consecutive cycles, c_commit one cycle after 04 accepted, no c_abort.
- Error packet: 3 words with i_err=1 on word 2 -> all 3 words written, then c_abort=1 for one cycle; the next good packet commits normally.
- Oversize packet: 20-word packet, eop on word 20 -> words 1..16 written, c_abort pulse, words 17..20 consumed with i_drdy=1 and not written; back in S_DATA after word 20.
- Exact-limit packet: 17 words with eop on word 17 -> 16 words written, c_abort, no S_DROP; a 16-word packet -> c_commit.
- Backpressure: c_drdy pattern 8'hA5 with input srdy pattern 8'h5A over 50 packets of random length 1..16 -> no word lost or duplicated, one pulse per packet, c_data stable while c_srdy&~c_drdy.
- Reset mid-packet: reset low after word 2 of 5 -> all outputs 0 immediately. After release, the first packet commits correctly; with SD_PKT_LOADER_STATS_EN, pkt_cnt=1.
